// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch sequencer.
// State encodings and the default interrupt vector.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_IRQ   = 2'd3
  } seq_state_t;

  localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h0000_0010;

  // halt outranks stall when both are raised
  function automatic seq_state_t resume_state(
    input logic halt,
    input logic stall
  );
    if (halt) return ST_IDLE;
    if (stall) return ST_STALL;
    return ST_FETCH;
  endfunction

endpackage

// File: rtl/program_counter_nbit.sv
// N-bit program counter.
// Load has priority over increment; resets to zero.
module program_counter_nbit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] PCdata,
  input  logic         PCload,
  input  logic         PCinc,
  output logic [N-1:0] PCout
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCout <= '0;
    end else if (PCload) begin
      PCout <= PCdata;
    end else if (PCinc) begin
      PCout <= PCout + ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: drives the PC counter and the
// imem handshake, with branch, irq and iret handling.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          N       = 32,
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         halt,
  input  logic         stall,
  input  logic         branch_take,
  input  logic [N-1:0] branch_target,
  input  logic         irq_req,
  input  logic         iret,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  output logic         irq_ack,
  output logic         in_irq,
  output logic [N-1:0] epc,
  output logic         busy
);

  localparam logic [N-1:0] VEC = N'(IRQ_VEC);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  seq_state_t   state;
  logic [N-1:0] pc;
  logic [N-1:0] pc_plus1;
  logic [N-1:0] pc_data;
  logic         pc_load;
  logic         pc_inc;
  logic         boundary;
  logic         take_irq;
  logic         do_iret;

  assign pc_plus1 = pc + ONE;
  assign boundary = (state == ST_FETCH) && imem_ack;
  assign take_irq = boundary && irq_req && !in_irq;
  assign do_iret  = boundary && !take_irq && !branch_take
                    && iret && in_irq;

  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    pc_data = branch_target;
    if (state == ST_IRQ) begin
      pc_load = 1'b1;
      pc_data = VEC;
    end else if (boundary && !take_irq) begin
      if (branch_take) begin
        pc_load = 1'b1;
      end else if (do_iret) begin
        pc_load = 1'b1;
        pc_data = epc;
      end else begin
        pc_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      epc    <= '0;
      in_irq <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (take_irq) state <= ST_IRQ;
          else if (boundary) state <= resume_state(halt, stall);
        end
        ST_STALL: state <= resume_state(halt, stall);
        ST_IRQ:   state <= resume_state(halt, stall);
      endcase
      // return lands on the branch target if one coincided
      if (take_irq)
        epc <= branch_take ? branch_target : pc_plus1;
      if (state == ST_IRQ) in_irq <= 1'b1;
      else if (do_iret) in_irq <= 1'b0;
    end
  end

  assign imem_req  = (state == ST_FETCH);
  assign irq_ack   = (state == ST_IRQ);
  assign busy      = (state != ST_IDLE);
  assign imem_addr = pc;

  program_counter_nbit #(.N(N)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .PCdata (pc_data),
    .PCload (pc_load),
    .PCinc  (pc_inc),
    .PCout  (pc)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random
// stimulus against a behavioural model (N=32 and N=4).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, stall, br, irq, iret, ack;
  logic [31:0] tgt;

  logic        req, irqa, inirq, busy;
  logic [31:0] addr, epc;
  logic        req4, irqa4, inirq4, busy4;
  logic [3:0]  addr4, epc4;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_VEC} mode_t;
  mode_t       m;
  logic [31:0] mpc, mepc;
  logic        mirq;

  always #5 clk = ~clk;

  pc_sequencer #(.N(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .stall(stall), .branch_take(br), .branch_target(tgt),
    .irq_req(irq), .iret(iret), .imem_req(req),
    .imem_addr(addr), .imem_ack(ack), .irq_ack(irqa),
    .in_irq(inirq), .epc(epc), .busy(busy)
  );

  pc_sequencer #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .stall(stall), .branch_take(br), .branch_target(tgt[3:0]),
    .irq_req(irq), .iret(iret), .imem_req(req4),
    .imem_addr(addr4), .imem_ack(ack), .irq_ack(irqa4),
    .in_irq(inirq4), .epc(epc4), .busy(busy4)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m = M_IDLE; mpc = '0; mepc = '0; mirq = 1'b0;
  endtask

  function automatic mode_t next_mode();
    if (halt) return M_IDLE;
    if (stall) return M_PAUSE;
    return M_RUN;
  endfunction

  // one clock of the fetch rules, using the current inputs
  task automatic model_clock();
    case (m)
      M_IDLE: if (start) m = M_RUN;
      M_RUN: if (ack) begin
        if (irq && !mirq) begin
          mepc = br ? tgt : mpc + 32'd1;
          m = M_VEC;
        end else begin
          if (br) mpc = tgt;
          else if (iret && mirq) begin
            mpc = mepc; mirq = 1'b0;
          end else mpc = mpc + 32'd1;
          m = next_mode();
        end
      end
      M_VEC: begin
        mpc = 32'h10; mirq = 1'b1; m = next_mode();
      end
      M_PAUSE: m = next_mode();
    endcase
  endtask

  task automatic check_all();
    chk("req", 32'(req), 32'(m == M_RUN));
    chk("addr", addr, mpc);
    chk("irq_ack", 32'(irqa), 32'(m == M_VEC));
    chk("in_irq", 32'(inirq), 32'(mirq));
    chk("epc", epc, mepc);
    chk("busy", 32'(busy), 32'(m != M_IDLE));
    chk("req4", 32'(req4), 32'(m == M_RUN));
    chk("addr4", 32'(addr4), 32'(mpc[3:0]));
    chk("irq_ack4", 32'(irqa4), 32'(m == M_VEC));
    chk("in_irq4", 32'(inirq4), 32'(mirq));
    chk("epc4", 32'(epc4), 32'(mepc[3:0]));
    chk("busy4", 32'(busy4), 32'(m != M_IDLE));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; br = 0; irq = 0;
    iret = 0; ack = 0; tgt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [31:0] a0;

  initial begin
    do_reset();
    chk("rst_addr", addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // sequential fetch, zero-wait memory
    start = 1; ack = 1;
    step();
    start = 0;
    chk("seq0", addr, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq", addr, 32'(i));
      chk("seq_busy", 32'(busy), 32'd1);
    end

    // branch at the boundary for address 5
    br = 1; tgt = 32'h40;
    step();
    chk("branch", addr, 32'h40);

    // interrupt coinciding with a branch
    irq = 1; tgt = 32'h80;
    step();
    chk("irq_epc", epc, 32'h80);
    chk("irq_ack1", 32'(irqa), 32'd1);
    br = 0;
    step();
    chk("irq_vec", addr, 32'h10);
    chk("irq_ack0", 32'(irqa), 32'd0);
    chk("irq_in", 32'(inirq), 32'd1);
    step();
    chk("irq_mask", addr, 32'h11);
    irq = 0;
    step();
    iret = 1;
    step();
    chk("iret_addr", addr, 32'h80);
    chk("iret_clr", 32'(inirq), 32'd0);
    iret = 0;

    // wait states with stall raised mid-wait
    ack = 0;
    step();
    a0 = addr;
    stall = 1;
    step();
    chk("wait_addr", addr, a0);
    chk("wait_req", 32'(req), 32'd1);
    step();
    ack = 1;
    step();
    chk("stall_req", 32'(req), 32'd0);
    chk("stall_pc", addr, a0 + 32'd1);
    ack = 0;
    step();
    stall = 0;
    step();
    chk("resume_req", 32'(req), 32'd1);
    chk("resume_pc", addr, a0 + 32'd1);

    // wrap-around at the top of both widths
    ack = 1; br = 1; tgt = 32'hFFFF_FFFF;
    step();
    chk("top4", 32'(addr4), 32'hF);
    br = 0;
    step();
    chk("wrap32", addr, 32'h0);
    chk("wrap4", 32'(addr4), 32'h0);

    // reset while a request is outstanding
    ack = 0;
    step();
    chk("pend_req", 32'(req), 32'd1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("arst_req", 32'(req), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // halt at a boundary
    start = 1;
    step();
    start = 0; ack = 1; halt = 1;
    step();
    chk("halt_busy", 32'(busy), 32'd0);
    halt = 0;

    // random phase
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4) == 0;
      halt  = ($urandom % 25) == 0;
      stall = ($urandom % 6) == 0;
      br    = ($urandom % 5) == 0;
      tgt   = ($urandom % 8) == 0 ?
              (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      irq   = ($urandom % 8) == 0;
      iret  = ($urandom % 5) == 0;
      ack   = ($urandom % 3) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
